switch_sampler: RTL and testbench
=================================

Name: switch_sampler

Overview:
Upstream conditioning stage for the sequence-detector FSM. It synchronises and debounces the raw slide-switch input, and generates a periodic one-cycle clock-enable tick. It presents the detector with a clean input level that is sampled only on that tick. The detector runs on clk gated by tick; no derived clock exists anywhere in the design.

Parameters:
DIV, 3, tick period in clk cycles; legal range is 2 or more.
DEB_CNT, 4, cycles the synchronised input must hold a new value before it is accepted; legal range is 1 or more.
SYNC_STAGES, 2, synchroniser flop count; legal range is 2 or more.

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
rst  in  1  synchronous reset, active-low
x_raw  in  1  asynchronous switch input (SW[1])
tick  out  1  clock-enable strobe, high for exactly one cycle every DIV cycles
x  out  1  debounced input level, updated only at tick edges; this feeds the detector's x
x_chg  out  1  one-cycle pulse, coincident with x updating to a new value

Behaviour:
- Reset: sampled only at a clk rising edge while rst==0. Every flop returns to its reset value at that edge.
  - synchroniser: 0; debounce state: IDLE_LO; debounce counter: 0; divider counter: 0.
  - outputs: x=0, x_chg=0, tick=0.
  - Reset mid-operation aborts any WAIT in progress, and the divider phase restarts.
- Synchroniser: SYNC_STAGES-flop shift chain; sync = last stage.
- Debounce FSM, with states IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO:
  - IDLE_LO: if sync==1, go to WAIT_HI with dcnt=0; otherwise stay.
  - WAIT_HI: if sync==0, return to IDLE_LO with dcnt=0 (glitch rejected; nothing downstream changes). Else if dcnt==DEB_CNT-1, go to IDLE_HI. Else dcnt+1.
  - IDLE_HI and WAIT_LO mirror the above with polarity inverted.
  - stable = 1 in IDLE_HI and WAIT_LO, else 0.
- Debounce latency: for a clean step held on x_raw, stable changes at edge SYNC_STAGES+1+DEB_CNT, counted from the first edge that samples the new value. With defaults this is edge 7.
- Debounce counter width is clog2(DEB_CNT) bits, minimum 1. It never wraps.
- Divider:
  - dvcnt counts 0..DIV-1 and wraps to 0.
  - tick = (dvcnt==DIV-1) && rst==1, decoded combinationally from the register.
  - The first tick after reset release is in cycle DIV. Its period is exactly DIV cycles, with no drift.
- Tick sampling: at an edge with tick==1, x <= stable and x_chg <= (stable != x). At every other edge, x holds and x_chg <= 0.
- x_chg is therefore high for the single cycle after the tick edge. It never asserts twice without an intervening tick.
- Simultaneous events:
  - A debounce acceptance and a tick on the same edge: x takes the old stable value, because the registered value is read. The new value appears at the next tick.
  - rst==0 at a tick edge: reset wins.
- DEB_CNT==1: acceptance happens on the first WAIT cycle that still sees the new value.

Decomposition:
- Shared package lab_pkg holds:
  - deb_state_t, a 2-bit enum for the four debounce states;
  - default constants DIV_DEF=3, DEB_CNT_DEF=4, SYNC_STAGES_DEF=2.
- One sub-module, tick_gen, containing the divider. It has parameter DIV and ports clk, rst, tick. The detector top level reuses it.
- Synchroniser, debounce FSM and sampling register stay inline.

Test Plan:
- Reset: hold rst=0 for 3 cycles with x_raw=1, then release. Required: x=0 and x_chg=0 throughout reset; first tick in cycle 3 after release; ticks every 3 cycles thereafter; 20 ticks observed in 60 cycles.
- Clean rise: x_raw 0→1 held, defaults. Required: stable rises at edge 7; x rises at the first tick edge at or after edge 8; x_chg is high for exactly one cycle after that edge.
- Glitch reject: x_raw pulses high for 3 cycles, then low (shorter than SYNC+DEB window). Required: FSM returns to IDLE_LO; x stays 0; x_chg is never asserted.
- Bounce then settle: x_raw toggles 1,0,1,0,1 on consecutive cycles, then holds at 1. Required: x rises exactly once; exactly one x_chg pulse; acceptance occurs 7 edges after the final 0→1.
- Reset mid-WAIT: assert rst=0 while the FSM is in WAIT_HI with dcnt=2. Required: next edge gives IDLE_LO, dcnt=0, dvcnt=0, x=0; after release the debounce restarts from zero.
- Parameter sweep: DIV=2 with DEB_CNT=1, and DIV=7 with DEB_CNT=8. Required: tick period equals DIV; acceptance latency equals SYNC_STAGES+1+DEB_CNT edges.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared types and default constants for the switch conditioning path and detector.
package lab_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  localparam int DIV_DEF         = 3;
  localparam int DEB_CNT_DEF     = 4;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle clock-enable every DIV cycles.
module tick_gen
  import lab_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] dvcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dvcnt <= '0;
    end else if (dvcnt == LAST) begin
      dvcnt <= '0;
    end else begin
      dvcnt <= dvcnt + 1'b1;
    end
  end

  // Gated by rst so no strobe escapes while reset is held.
  assign tick = (dvcnt == LAST) && rst;

endmodule

// File: rtl/switch_sampler.sv
// Synchronises and debounces the raw switch, then presents it to the detector
// only on the divider tick.
module switch_sampler
  import lab_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int DEB_CNT     = DEB_CNT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic x_raw,
  output logic tick,
  output logic x,
  output logic x_chg
);

  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  deb_state_t             state;
  logic [DW-1:0]          dcnt;
  logic                   stable;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], x_raw};
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // stable is registered alongside the state so it flips on the acceptance edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE_LO;
      dcnt   <= '0;
      stable <= 1'b0;
    end else begin
      case (state)
        IDLE_LO: begin
          if (sync) begin
            state <= WAIT_HI;
            dcnt  <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync) begin
            state <= IDLE_LO;
            dcnt  <= '0;
          end else if (dcnt == DEB_LAST) begin
            state  <= IDLE_HI;
            stable <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!sync) begin
            state <= WAIT_LO;
            dcnt  <= '0;
          end
        end
        WAIT_LO: begin
          if (sync) begin
            state <= IDLE_HI;
            dcnt  <= '0;
          end else if (dcnt == DEB_LAST) begin
            state  <= IDLE_LO;
            stable <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LO;
          dcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x     <= 1'b0;
      x_chg <= 1'b0;
    end else if (tick) begin
      x     <= stable;
      x_chg <= (stable != x);
    end else begin
      x_chg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_sampler.sv
// Drives three sampler configurations in parallel and checks them against a
// run-length model of the debounce plus literal latency/tick-count expectations.
module tb_switch_sampler;
  import lab_pkg::*;

  localparam int N    = 3;
  localparam int SYNC = SYNC_STAGES_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x_raw = 1'b1;
  logic [N-1:0] tick_o, x_o, chg_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  switch_sampler #(.DIV(3), .DEB_CNT(4), .SYNC_STAGES(SYNC)) dut0 (
    .clk(clk), .rst(rst), .x_raw(x_raw), .tick(tick_o[0]), .x(x_o[0]), .x_chg(chg_o[0]));
  switch_sampler #(.DIV(2), .DEB_CNT(1), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst(rst), .x_raw(x_raw), .tick(tick_o[1]), .x(x_o[1]), .x_chg(chg_o[1]));
  switch_sampler #(.DIV(7), .DEB_CNT(8), .SYNC_STAGES(SYNC)) dut2 (
    .clk(clk), .rst(rst), .x_raw(x_raw), .tick(tick_o[2]), .x(x_o[2]), .x_chg(chg_o[2]));

  function automatic int div_of(int k);
    case (k)
      0: return 3;
      1: return 2;
      default: return 7;
    endcase
  endfunction

  function automatic int deb_of(int k);
    case (k)
      0: return 4;
      1: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic stable_of(int k);
    case (k)
      0: return dut0.stable;
      1: return dut1.stable;
      default: return dut2.stable;
    endcase
  endfunction

  task automatic check(string name, int k, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // Model: sync is x_raw delayed SYNC edges; a new level is accepted after
  // DEB_CNT+1 consecutive edges disagreeing with the accepted level.
  bit started = 1'b0;
  int n_m[N];
  int run_m[N];
  bit stab_m[N], x_m[N], chg_m[N];
  bit hist_m[N][SYNC];

  always @(posedge clk) begin
    bit tk;
    bit s;
    for (int k = 0; k < N; k++) begin
      if (!rst) begin
        n_m[k] = 0; run_m[k] = 0; stab_m[k] = 0; x_m[k] = 0; chg_m[k] = 0;
        for (int i = 0; i < SYNC; i++) hist_m[k][i] = 0;
        started = 1'b1;
      end else begin
        tk = (n_m[k] % div_of(k)) == div_of(k) - 1;
        s  = hist_m[k][SYNC-1];
        if (tk) begin
          chg_m[k] = (stab_m[k] != x_m[k]);
          x_m[k]   = stab_m[k];
        end else begin
          chg_m[k] = 0;
        end
        if (s != stab_m[k]) begin
          run_m[k]++;
          if (run_m[k] == deb_of(k) + 1) begin
            stab_m[k] = s;
            run_m[k]  = 0;
          end
        end else begin
          run_m[k] = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) hist_m[k][i] = hist_m[k][i-1];
        hist_m[k][0] = x_raw;
        n_m[k]++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < N; k++) begin
        check("tick", k, int'(tick_o[k]), int'(rst && ((n_m[k] % div_of(k)) == div_of(k) - 1)));
        check("x", k, int'(x_o[k]), int'(x_m[k]));
        check("x_chg", k, int'(chg_o[k]), int'(chg_m[k]));
      end
    end
  end

  int chg_cnt[N] = '{0, 0, 0};
  int chg_base[N];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) chg_cnt[k] += int'(chg_o[k]);
  end

  task automatic snap();
    for (int k = 0; k < N; k++) chg_base[k] = chg_cnt[k];
  endtask

  task automatic chg_check(string name, int k, int exp);
    check(name, k, chg_cnt[k] - chg_base[k], exp);
  endtask

  task automatic step_raw(logic v);
    @(posedge clk);
    #2 x_raw = v;
  endtask

  // Edge count from the first edge sampling the new value until stable follows.
  task automatic measure(string name, logic v, int e0, int e1, int e2);
    int lat[N];
    for (int k = 0; k < N; k++) lat[k] = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (lat[k] == 0 && stable_of(k) == v) lat[k] = e;
    end
    check(name, 0, lat[0], e0);
    check(name, 1, lat[1], e1);
    check(name, 2, lat[2], e2);
  endtask

  initial begin
    int ticks[N];
    int first0;

    rst = 1'b0;
    x_raw = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    x_raw = 1'b0;

    for (int k = 0; k < N; k++) ticks[k] = 0;
    first0 = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) ticks[k] += int'(tick_o[k]);
      if (first0 == 0 && tick_o[0]) first0 = c;
      @(posedge clk);
      #2;
    end
    check("first_tick_cycle", 0, first0, 3);
    check("ticks_in_60", 0, ticks[0], 20);
    check("ticks_in_60", 1, ticks[1], 30);
    check("ticks_in_60", 2, ticks[2], 8);

    snap();
    step_raw(1'b1);
    measure("rise_latency", 1'b1, 7, 4, 11);
    for (int k = 0; k < N; k++) chg_check("rise_chg_pulses", k, 1);
    check("x_after_rise", 0, int'(x_o[0]), 1);

    snap();
    step_raw(1'b0);
    measure("fall_latency", 1'b0, 7, 4, 11);
    for (int k = 0; k < N; k++) chg_check("fall_chg_pulses", k, 1);

    snap();
    step_raw(1'b1);
    repeat (2) @(posedge clk);
    step_raw(1'b0);
    repeat (30) @(posedge clk);
    #1;
    chg_check("glitch_chg_pulses", 0, 0);
    chg_check("glitch_chg_pulses", 2, 0);
    check("glitch_x", 0, int'(x_o[0]), 0);
    check("glitch_state", 0, int'(dut0.state), int'(IDLE_LO));

    snap();
    step_raw(1'b1);
    step_raw(1'b0);
    step_raw(1'b1);
    step_raw(1'b0);
    step_raw(1'b1);
    measure("bounce_latency", 1'b1, 7, 4, 11);
    for (int k = 0; k < N; k++) chg_check("bounce_chg_pulses", k, 1);

    step_raw(1'b0);
    measure("settle_low_latency", 1'b0, 7, 4, 11);

    step_raw(1'b1);
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_state", 0, int'(dut0.state), int'(WAIT_HI));
    check("pre_reset_dcnt", 0, int'(dut0.dcnt), 2);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midwait_state", 0, int'(dut0.state), int'(IDLE_LO));
    check("midwait_dcnt", 0, int'(dut0.dcnt), 0);
    check("midwait_dvcnt", 0, int'(dut0.u_tick_gen.dvcnt), 0);
    check("midwait_x", 0, int'(x_o[0]), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    measure("restart_latency", 1'b1, 7, 4, 11);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
